// File: rtl/wbuhostmux_pkg.sv
// Shared tag and payload definitions for the host-side debug-bus/console link mux.
package wbuhostmux_pkg;

  localparam logic TAG_CMD   = 1'b1;
  localparam logic TAG_CON   = 1'b0;
  localparam int   TAG_BIT   = 7;
  localparam int   PAYLOAD_W = 7;

  function automatic logic [PAYLOAD_W:0] tag_byte(input logic tag,
                                                  input logic [PAYLOAD_W-1:0] payload);
    return {tag, payload};
  endfunction

endpackage

// File: rtl/wbuhostmux_fifo.sv
// Synchronous FIFO for one inbound stream; pointers carry an extra wrap bit so
// full and empty are distinguished without a counter.
module wbuhostmux_fifo
  import wbuhostmux_pkg::*;
#(
  parameter int LGFIFO = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_push,
  input  logic [PAYLOAD_W-1:0] i_data,
  input  logic                 i_pop,
  output logic [PAYLOAD_W-1:0] o_data,
  output logic                 o_full,
  output logic                 o_empty_n
);

  logic [PAYLOAD_W-1:0] mem [1<<LGFIFO];
  logic [LGFIFO:0]      wr_ptr;
  logic [LGFIFO:0]      rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign o_empty_n = (wr_ptr != rd_ptr);
  assign o_full    = (wr_ptr[LGFIFO] != rd_ptr[LGFIFO]) &&
                     (wr_ptr[LGFIFO-1:0] == rd_ptr[LGFIFO-1:0]);
  assign do_pop    = i_pop && o_empty_n;
  // A pop frees the slot on the same edge, so a full FIFO still takes the push.
  assign do_push   = i_push && (!o_full || do_pop);
  assign o_data    = mem[rd_ptr[LGFIFO-1:0]];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + {{LGFIFO{1'b0}}, 1'b1};
      if (do_pop)
        rd_ptr <= rd_ptr + {{LGFIFO{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push)
      mem[wr_ptr[LGFIFO-1:0]] <= i_data;
  end

endmodule

// File: rtl/wbuhostmux.sv
// Host-side link mux: tags and merges outbound cmd/console bytes, splits inbound
// bytes by tag into two FIFOs. Define WBUHOSTMUX_FAIR_ARB_EN for round-robin TX arbitration.
module wbuhostmux
  import wbuhostmux_pkg::*;
#(
  parameter int LGFIFO = 4,
  parameter int DROPW  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_cmd_stb,
  input  logic [PAYLOAD_W-1:0] i_cmd_data,
  output logic                 o_cmd_busy,
  input  logic                 i_con_stb,
  input  logic [PAYLOAD_W-1:0] i_con_data,
  output logic                 o_con_busy,
  output logic                 o_tx_stb,
  output logic [PAYLOAD_W:0]   o_tx_data,
  input  logic                 i_tx_busy,
  input  logic                 i_rx_stb,
  input  logic [PAYLOAD_W:0]   i_rx_data,
  output logic                 o_rcmd_stb,
  output logic [PAYLOAD_W-1:0] o_rcmd_data,
  input  logic                 i_rcmd_busy,
  output logic                 o_rcon_stb,
  output logic [PAYLOAD_W-1:0] o_rcon_data,
  input  logic                 i_rcon_busy,
  output logic [DROPW-1:0]     o_drop_cnt
);

  logic tx_free;
  logic prefer_con;
  logic grant_cmd;
  logic grant_con;

  assign tx_free    = !o_tx_stb || !i_tx_busy;
  assign o_cmd_busy = !tx_free || (i_con_stb && prefer_con);
  assign o_con_busy = !tx_free || (i_cmd_stb && !prefer_con);
  assign grant_cmd  = i_cmd_stb && !o_cmd_busy;
  assign grant_con  = i_con_stb && !o_con_busy;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_tx_stb  <= 1'b0;
      o_tx_data <= '0;
    end else if (grant_cmd) begin
      o_tx_stb  <= 1'b1;
      o_tx_data <= tag_byte(TAG_CMD, i_cmd_data);
    end else if (grant_con) begin
      o_tx_stb  <= 1'b1;
      o_tx_data <= tag_byte(TAG_CON, i_con_data);
    end else if (!i_tx_busy) begin
      o_tx_stb  <= 1'b0;
    end
  end

`ifdef WBUHOSTMUX_FAIR_ARB_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      prefer_con <= 1'b0;
    else if (grant_cmd || grant_con)
      prefer_con <= !prefer_con;
  end
`else
  assign prefer_con = 1'b0;
`endif

  logic push_cmd, push_con, pop_cmd, pop_con, full_cmd, full_con, drop;

  assign push_cmd = i_rx_stb && (i_rx_data[TAG_BIT] == TAG_CMD);
  assign push_con = i_rx_stb && (i_rx_data[TAG_BIT] == TAG_CON);
  assign pop_cmd  = o_rcmd_stb && !i_rcmd_busy;
  assign pop_con  = o_rcon_stb && !i_rcon_busy;
  assign drop     = (push_cmd && full_cmd && !pop_cmd) ||
                    (push_con && full_con && !pop_con);

  wbuhostmux_fifo #(.LGFIFO(LGFIFO)) u_cmd_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (push_cmd),
    .i_data    (i_rx_data[PAYLOAD_W-1:0]),
    .i_pop     (pop_cmd),
    .o_data    (o_rcmd_data),
    .o_full    (full_cmd),
    .o_empty_n (o_rcmd_stb)
  );

  wbuhostmux_fifo #(.LGFIFO(LGFIFO)) u_con_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (push_con),
    .i_data    (i_rx_data[PAYLOAD_W-1:0]),
    .i_pop     (pop_con),
    .o_data    (o_rcon_data),
    .o_full    (full_con),
    .o_empty_n (o_rcon_stb)
  );

  // Saturate rather than wrap so a large loss never reads back as a small one.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      o_drop_cnt <= '0;
    else if (drop && (o_drop_cnt != {DROPW{1'b1}}))
      o_drop_cnt <= o_drop_cnt + {{(DROPW-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_wbuhostmux.sv
// Self-checking bench for wbuhostmux: directed scenarios plus randomized traffic
// against a queue-based reference model of the link mux.
module tb_wbuhostmux;

  localparam int LGFIFO   = 4;
  localparam int DROPW    = 8;
  localparam int DEPTH    = 1 << LGFIFO;
  localparam int DROP_MAX = (1 << DROPW) - 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_stb, con_stb, tx_busy, rx_stb, rcmd_busy, rcon_busy;
  logic [6:0] cmd_data, con_data;
  logic [7:0] rx_data;
  logic       cmd_busy, con_busy, tx_stb, rcmd_stb, rcon_stb;
  logic [7:0] tx_data;
  logic [6:0] rcmd_data, rcon_data;
  logic [DROPW-1:0] drop_cnt;

  always #5 clk = ~clk;

  wbuhostmux #(.LGFIFO(LGFIFO), .DROPW(DROPW)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_cmd_stb   (cmd_stb),
    .i_cmd_data  (cmd_data),
    .o_cmd_busy  (cmd_busy),
    .i_con_stb   (con_stb),
    .i_con_data  (con_data),
    .o_con_busy  (con_busy),
    .o_tx_stb    (tx_stb),
    .o_tx_data   (tx_data),
    .i_tx_busy   (tx_busy),
    .i_rx_stb    (rx_stb),
    .i_rx_data   (rx_data),
    .o_rcmd_stb  (rcmd_stb),
    .o_rcmd_data (rcmd_data),
    .i_rcmd_busy (rcmd_busy),
    .o_rcon_stb  (rcon_stb),
    .o_rcon_data (rcon_data),
    .i_rcon_busy (rcon_busy),
    .o_drop_cnt  (drop_cnt)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: one-entry TX slot, two bounded queues, saturating drop count.
  logic       m_tx_valid;
  logic [7:0] m_tx_byte;
  logic [6:0] cmd_q[$];
  logic [6:0] con_q[$];
  int         m_drop;
  logic       m_turn_con;
  logic       last_cmd_acc, last_con_acc;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    m_tx_valid   = 1'b0;
    m_tx_byte    = 8'h00;
    cmd_q.delete();
    con_q.delete();
    m_drop       = 0;
    m_turn_con   = 1'b0;
    last_cmd_acc = 1'b0;
    last_con_acc = 1'b0;
  endtask

  task automatic driveIdle();
    cmd_stb = 0; cmd_data = '0; con_stb = 0; con_data = '0; tx_busy = 0;
    rx_stb = 0; rx_data = '0; rcmd_busy = 0; rcon_busy = 0;
  endtask

  task automatic doReset();
    driveIdle();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_tx_stb", tx_stb, 0);
    checkOutput("rst_tx_data", tx_data, 0);
    checkOutput("rst_rcmd_stb", rcmd_stb, 0);
    checkOutput("rst_rcon_stb", rcon_stb, 0);
    checkOutput("rst_drop", drop_cnt, 0);
    modelReset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1: drives one cycle, checks mid-cycle, advances the model at the edge.
  task automatic applyStimulus(input logic cs, input logic [6:0] cd,
                               input logic ns, input logic [6:0] nd,
                               input logic tb, input logic rs, input logic [7:0] rd,
                               input logic rcb, input logic rnb);
    logic free, cmd_acc, con_acc;
    cmd_stb = cs; cmd_data = cd; con_stb = ns; con_data = nd; tx_busy = tb;
    rx_stb = rs; rx_data = rd; rcmd_busy = rcb; rcon_busy = rnb;
    #3;
    free = !m_tx_valid || !tb;
`ifdef WBUHOSTMUX_FAIR_ARB_EN
    cmd_acc = cs && free && (!ns || !m_turn_con);
    con_acc = ns && free && (!cs || m_turn_con);
`else
    cmd_acc = cs && free;
    con_acc = ns && free && !cs;
`endif
    checkOutput("tx_stb", tx_stb, m_tx_valid);
    if (m_tx_valid) checkOutput("tx_data", tx_data, m_tx_byte);
    if (cs) checkOutput("cmd_busy", cmd_busy, !cmd_acc);
    if (ns) checkOutput("con_busy", con_busy, !con_acc);
    checkOutput("rcmd_stb", rcmd_stb, cmd_q.size() != 0);
    if (cmd_q.size() != 0) checkOutput("rcmd_data", rcmd_data, cmd_q[0]);
    checkOutput("rcon_stb", rcon_stb, con_q.size() != 0);
    if (con_q.size() != 0) checkOutput("rcon_data", rcon_data, con_q[0]);
    checkOutput("drop_cnt", drop_cnt, m_drop);
    @(posedge clk);
    if (m_tx_valid && !tb) m_tx_valid = 1'b0;
    if (cmd_acc) begin
      m_tx_valid = 1'b1; m_tx_byte = {1'b1, cd};
    end else if (con_acc) begin
      m_tx_valid = 1'b1; m_tx_byte = {1'b0, nd};
    end
`ifdef WBUHOSTMUX_FAIR_ARB_EN
    if (cmd_acc || con_acc) m_turn_con = !m_turn_con;
`endif
    if (cmd_q.size() != 0 && !rcb) void'(cmd_q.pop_front());
    if (con_q.size() != 0 && !rnb) void'(con_q.pop_front());
    if (rs) begin
      if (rd[7]) begin
        if (cmd_q.size() < DEPTH) cmd_q.push_back(rd[6:0]);
        else if (m_drop < DROP_MAX) m_drop++;
      end else begin
        if (con_q.size() < DEPTH) con_q.push_back(rd[6:0]);
        else if (m_drop < DROP_MAX) m_drop++;
      end
    end
    last_cmd_acc = cmd_acc;
    last_con_acc = con_acc;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 7'h00, 0, 7'h00, 0, 0, 8'h00, 0, 0);
  endtask

  logic       r_cs, r_ns;
  logic [6:0] r_cd, r_nd;
  int         busy_pct;

  initial begin
    rst_n = 1'b0;
    driveIdle();
    modelReset();

    // Single command byte goes out tagged, for one cycle.
    doReset();
    applyStimulus(1, 7'h41, 0, 7'h00, 0, 0, 8'h00, 0, 0);
    checkOutput("t1_data", tx_data, 8'hC1);
    idleCycle();
    checkOutput("t1_one_cycle", tx_stb, 0);

    // Simultaneous cmd and console: cmd first, console retries.
    doReset();
    applyStimulus(1, 7'h10, 1, 7'h20, 0, 0, 8'h00, 0, 0);
    checkOutput("t2_first", tx_data, 8'h90);
    applyStimulus(0, 7'h00, 1, 7'h20, 0, 0, 8'h00, 0, 0);
    checkOutput("t2_second", tx_data, 8'h20);
    idleCycle();

    // RX demux keeps per-stream order.
    doReset();
    applyStimulus(0, 7'h00, 0, 7'h00, 0, 1, 8'hC5, 1, 1);
    applyStimulus(0, 7'h00, 0, 7'h00, 0, 1, 8'h33, 1, 1);
    applyStimulus(0, 7'h00, 0, 7'h00, 0, 1, 8'h80, 1, 1);
    checkOutput("t3_rcmd_head", rcmd_data, 8'h45);
    checkOutput("t3_rcon_head", rcon_data, 8'h33);
    applyStimulus(0, 7'h00, 0, 7'h00, 0, 0, 8'h00, 0, 1);
    checkOutput("t3_rcmd_next", rcmd_data, 8'h00);
    idleCycle();
    idleCycle();

    // Console FIFO overflow while stalled, then drain in order.
    doReset();
    for (int i = 0; i < 20; i++)
      applyStimulus(0, 7'h00, 0, 7'h00, 0, 1, {1'b0, 7'(i + 3)}, 0, 1);
    checkOutput("t4_drop", drop_cnt, 4);
    for (int i = 0; i < 17; i++) idleCycle();
    checkOutput("t4_drained", rcon_stb, 0);

    // Link stall holds the TX byte and backpressures both producers.
    doReset();
    applyStimulus(1, 7'h01, 0, 7'h00, 1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 10; i++)
      applyStimulus(1, 7'h02, 1, 7'h03, 1, 0, 8'h00, 0, 0);
    checkOutput("t5_held", tx_data, 8'h81);
    applyStimulus(1, 7'h02, 1, 7'h03, 0, 0, 8'h00, 0, 0);
    applyStimulus(0, 7'h00, 1, 7'h03, 0, 0, 8'h00, 0, 0);
    idleCycle();
    idleCycle();

    // Drop counter saturates.
    doReset();
    for (int i = 0; i < 280; i++)
      applyStimulus(0, 7'h00, 0, 7'h00, 0, 1, {1'b0, 7'(i)}, 0, 1);
    checkOutput("sat_drop", drop_cnt, DROP_MAX);

    // Asynchronous reset with a pending TX byte and partly full FIFOs.
    doReset();
    applyStimulus(1, 7'h55, 0, 7'h00, 1, 0, 8'h00, 1, 1);
    for (int i = 0; i < 18; i++)
      applyStimulus(0, 7'h00, 0, 7'h00, 1, 1, {1'b1, 7'(i)}, 1, 1);
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 7'h00, 0, 7'h00, 1, 1, {1'b0, 7'(i)}, 1, 1);
    checkOutput("t6_pre_drop", drop_cnt, 2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_tx_stb", tx_stb, 0);
    checkOutput("t6_tx_data", tx_data, 0);
    checkOutput("t6_rcmd_stb", rcmd_stb, 0);
    checkOutput("t6_rcon_stb", rcon_stb, 0);
    checkOutput("t6_drop", drop_cnt, 0);
    driveIdle();
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idleCycle();
    idleCycle();

    // Randomized traffic with a stall-heavy then a flowing phase.
    doReset();
    r_cs = 0; r_ns = 0; r_cd = '0; r_nd = '0;
    for (int i = 0; i < 1500; i++) begin
      busy_pct = (i < 750) ? 70 : 20;
      if (!r_cs || last_cmd_acc) begin
        r_cs = ($urandom_range(0, 99) < 50);
        r_cd = 7'($urandom);
      end
      if (!r_ns || last_con_acc) begin
        r_ns = ($urandom_range(0, 99) < 50);
        r_nd = 7'($urandom);
      end
      applyStimulus(r_cs, r_cd, r_ns, r_nd,
                    $urandom_range(0, 99) < 30,
                    $urandom_range(0, 99) < 60, 8'($urandom),
                    $urandom_range(0, 99) < busy_pct,
                    $urandom_range(0, 99) < busy_pct);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
